// File: rtl/halloween_pkg.sv
// Shared opcode encodings, FSM state type and opcode layout for the halloween sequencer.
package halloween_pkg;

   localparam logic [1:0] CLS_SYSTEM = 2'b00;
   localparam logic [1:0] CLS_COLOR  = 2'b01;
   localparam logic [1:0] CLS_SOUND  = 2'b10;
   localparam logic [1:0] CLS_EFFECT = 2'b11;

   localparam logic [1:0] ON        = 2'b00;
   localparam logic [1:0] RESET     = 2'b01;
   localparam logic [1:0] GREEN     = 2'b00;
   localparam logic [1:0] PURPLE    = 2'b01;
   localparam logic [1:0] ORANGE    = 2'b10;
   localparam logic [1:0] SCREAMING = 2'b00;
   localparam logic [1:0] CACKLING  = 2'b01;
   localparam logic [1:0] BOO       = 2'b10;
   localparam logic [1:0] WAVEHANDS = 2'b00;
   localparam logic [1:0] MOVEJAW   = 2'b01;
   localparam logic [1:0] FOG       = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_EXEC  = 2'd2,
      ST_HOLD  = 2'd3
   } state_t;

   typedef struct packed {
      logic [1:0] cls;
      logic [1:0] code;
   } opcode_t;

endpackage

// File: rtl/halloween_sequencer_rr_arbiter4.sv
// Combinational 4-way round-robin picker; the search starts at pointer.
module rr_arbiter4 (
   input  logic [3:0] req,
   input  logic [1:0] pointer,
   output logic [1:0] winner,
   output logic       any
);

   logic [1:0] idx;

   // Scan from the farthest offset down so the closest requester to pointer wins.
   always_comb begin
      winner = pointer;
      any    = 1'b0;
      idx    = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         idx = pointer + 2'(i);
         if (req[idx]) begin
            winner = idx;
            any    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/halloween_sequencer.sv
// Round-robin opcode sequencer: grants one requester at a time, decodes its
// opcode into power/colour/sound/effect controls, and holds timed opcodes.
//
// state    | meaning
// ST_IDLE  | waiting for a request; arbiter result registered into sel
// ST_GRANT | gnt[sel] pulses, opcode captured, pointer advanced
// ST_EXEC  | captured opcode applied (or rejected with err)
// ST_HOLD  | sound/effect running; cnt counts down to 0
module halloween_sequencer
   import halloween_pkg::*;
#(
   parameter int SOUND_CYCLES  = 8,
   parameter int EFFECT_CYCLES = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [3:0]      req,
   input  logic [3:0][3:0] opcode,
   output logic [3:0]      gnt,
   output logic [1:0]      sel,
   output logic            busy,
   output logic            power_on,
   output logic [1:0]      color,
   output logic            sound_active,
   output logic [1:0]      sound_id,
   output logic            effect_active,
   output logic [1:0]      effect_id,
   output logic            err
);

   localparam int MAX_DUR = (SOUND_CYCLES > EFFECT_CYCLES) ? SOUND_CYCLES : EFFECT_CYCLES;
   localparam int CNT_W   = (MAX_DUR > 1) ? $clog2(MAX_DUR) : 1;

   state_t           state, state_nxt;
   logic [1:0]       pointer;
   logic [1:0]       winner;
   logic             any;
   opcode_t          op_q;
   logic [CNT_W-1:0] cnt;
   logic             op_legal, op_exec, op_timed;

   rr_arbiter4 u_arb (
      .req     (req),
      .pointer (pointer),
      .winner  (winner),
      .any     (any)
   );

   // Opcode legality and whether it takes effect given the current power state.
   always_comb begin
      op_legal = 1'b1;
      case (op_q.cls)
         CLS_SYSTEM: op_legal = (op_q.code == ON) || (op_q.code == RESET);
         default:    op_legal = (op_q.code != 2'b11);
      endcase
      op_exec  = op_legal && (power_on || ((op_q.cls == CLS_SYSTEM) && (op_q.code == ON)));
      op_timed = op_exec && ((op_q.cls == CLS_SOUND) || (op_q.cls == CLS_EFFECT));
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (any) state_nxt = ST_GRANT;
         ST_GRANT: state_nxt = ST_EXEC;
         ST_EXEC:  state_nxt = op_timed ? ST_HOLD : ST_IDLE;
         ST_HOLD:  if (cnt == '0) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // State-decoded outputs.
   always_comb begin
      gnt  = (state == ST_GRANT) ? (4'b0001 << sel) : 4'b0000;
      busy = (state != ST_IDLE);
   end

   // Datapath: selection, pointer, opcode capture, decoded controls and hold timer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel           <= 2'd0;
         pointer       <= 2'd0;
         op_q          <= '0;
         cnt           <= '0;
         power_on      <= 1'b0;
         color         <= 2'b00;
         sound_active  <= 1'b0;
         sound_id      <= 2'b00;
         effect_active <= 1'b0;
         effect_id     <= 2'b00;
         err           <= 1'b0;
      end else begin
         err <= 1'b0;
         case (state)
            ST_IDLE: if (any) sel <= winner;
            ST_GRANT: begin
               op_q    <= opcode[sel];
               pointer <= sel + 2'd1;
            end
            ST_EXEC: begin
               if (!op_exec) begin
                  err <= 1'b1;
               end else begin
                  case (op_q.cls)
                     CLS_SYSTEM: begin
                        if (op_q.code == ON) begin
                           power_on <= 1'b1;
                        end else begin
                           power_on      <= 1'b0;
                           color         <= 2'b00;
                           sound_active  <= 1'b0;
                           effect_active <= 1'b0;
                        end
                     end
                     CLS_COLOR: color <= op_q.code;
                     CLS_SOUND: begin
                        sound_active <= 1'b1;
                        sound_id     <= op_q.code;
                        cnt          <= CNT_W'(SOUND_CYCLES - 1);
                     end
                     default: begin
                        effect_active <= 1'b1;
                        effect_id     <= op_q.code;
                        cnt           <= CNT_W'(EFFECT_CYCLES - 1);
                     end
                  endcase
               end
            end
            ST_HOLD: begin
               if (cnt == '0) begin
                  sound_active  <= 1'b0;
                  effect_active <= 1'b0;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
